s2p_frame_drain: RTL

//  Downstream of the byte-to-frame shifter. Captures each completed 2048-bit frame on its

---
 rtl/s2p_frame_drain.sv | 68 ++++++
 1 files changed

// File: rtl/s2p_frame_drain.sv
// s2p_frame_drain: ping-pong frame buffer drained oldest-word-first on a valid/ready stream
// Optional FRAME_SEQ_EN adds an 8-bit per-frame sequence tag on out_seq.
module s2p_frame_drain #(
  parameter int FRAME_W = 2048,
  parameter int WORD_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         out_seq
);
  localparam int NWORDS = FRAME_W / WORD_W;
  localparam int KW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] KMAX = KW'(NWORDS - 1);
  logic [NWORDS-1:0][WORD_W-1:0] mem [2];
  logic [1:0] full, full_n;
  logic wsel, rsel, hs, last_hs, cap;
  logic [KW-1:0] k;
  // Writes and reads alternate buffers, so full[wsel] implies both buffers are full
  // and wsel==rsel; a last-word handshake then frees exactly the buffer being written.
  always_comb begin
    hs = out_valid && out_ready;
    last_hs = hs && k == KMAX;
    cap = frame_valid && (!full[wsel] || (last_hs && rsel == wsel));
    full_n = full;
    if (last_hs) full_n[rsel] = 1'b0;
    if (cap) full_n[wsel] = 1'b1;
  end
  assign out_valid = full[rsel];
  assign out_data  = out_valid ? mem[rsel][KMAX - k] : '0;
  assign out_last  = out_valid && k == KMAX;
  assign busy      = |full;
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      k <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_n;
      if (hs) k <= last_hs ? '0 : k + 1'b1;
      if (last_hs) rsel <= ~rsel;
      if (cap) wsel <= ~wsel;
      else if (frame_valid) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (cap) mem[wsel] <= frame_data;
`ifdef FRAME_SEQ_EN
  logic [7:0] seq;
  logic [7:0] tag [2];
  always_ff @(posedge clk) begin
    if (rst) seq <= '0;
    else if (cap) seq <= seq + 8'd1;
  end
  always_ff @(posedge clk) if (cap) tag[wsel] <= seq;
  assign out_seq = out_valid ? tag[rsel] : '0;
`else
  assign out_seq = '0;
`endif
endmodule
